// File: rtl/wb_register_master.sv
// wb_register_master: Wishbone initiator turning single-word register commands into classic bus cycles.
// Define WBM_TIMEOUT_EN to bound the ACK wait to TIMEOUT_CYCLES and report an error response.
module wb_register_master #(
  parameter int ADDRWIDTH      = 7,
  parameter int DATAWIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNTWIDTH       = 16
) (
  input  logic                 WBs_CLK_i,
  input  logic                 WBs_RST_i,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic                 cmd_we_i,
  input  logic [ADDRWIDTH-1:0] cmd_adr_i,
  input  logic [DATAWIDTH-1:0] cmd_dat_i,
  input  logic [3:0]           cmd_be_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [DATAWIDTH-1:0] rsp_dat_o,
  output logic                 rsp_err_o,
  output logic [ADDRWIDTH-1:0] WBm_ADR_o,
  output logic                 WBm_CYC_o,
  output logic                 WBm_STB_o,
  output logic                 WBm_WE_o,
  output logic [3:0]           WBm_BYTE_STB_o,
  output logic [DATAWIDTH-1:0] WBm_DAT_o,
  input  logic [DATAWIDTH-1:0] WBm_DAT_i,
  input  logic                 WBm_ACK_i,
  output logic                 busy_o,
  output logic [CNTWIDTH-1:0]  txn_count_o
);
  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
  state_t               state_q, state_d;
  logic                 ready_q, ready_d;
  logic                 cyc_q, cyc_d;
  logic                 we_q, we_d;
  logic [ADDRWIDTH-1:0] adr_q, adr_d;
  logic [DATAWIDTH-1:0] dat_q, dat_d;
  logic [3:0]           be_q, be_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [DATAWIDTH-1:0] rsp_dat_q, rsp_dat_d;
  logic                 rsp_err_q, rsp_err_d;
  logic [CNTWIDTH-1:0]  cnt_q, cnt_d;
  logic                 expired;
`ifdef WBM_TIMEOUT_EN
  localparam int TW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [TW-1:0] wait_q, wait_d;
  // Held at zero outside BUS so it starts cleared on every bus entry.
  always_comb wait_d = (state_q == BUS) ? wait_q + 1'b1 : '0;
  assign expired = (state_q == BUS) && (wait_q == TW'(TIMEOUT_CYCLES - 1));
  always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i)
    if (WBs_RST_i) wait_q <= '0;
    else wait_q <= wait_d;
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = TIMEOUT_CYCLES;
  assign expired = 1'b0;
`endif
  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    we_d        = we_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    be_d        = be_q;
    rsp_valid_d = rsp_valid_q;
    rsp_dat_d   = rsp_dat_q;
    rsp_err_d   = rsp_err_q;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE: if (cmd_valid_i && ready_q) begin
        state_d = BUS;
        cyc_d   = 1'b1;
        we_d    = cmd_we_i;
        adr_d   = cmd_adr_i;
        dat_d   = cmd_dat_i;
        be_d    = cmd_be_i;
      end
      // ACK takes priority over an expiring wait counter.
      BUS: if (WBm_ACK_i || expired) begin
        state_d     = RESP;
        cyc_d       = 1'b0;
        rsp_valid_d = 1'b1;
        rsp_err_d   = !WBm_ACK_i;
        rsp_dat_d   = (WBm_ACK_i && !we_q) ? WBm_DAT_i : '0;
        cnt_d       = cnt_q + 1'b1;
      end
      RESP: if (rsp_ready_i) begin
        state_d     = IDLE;
        rsp_valid_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
  end
  always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i)
    if (WBs_RST_i) begin
      state_q     <= IDLE;
      ready_q     <= 1'b0;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      dat_q       <= '0;
      be_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
      rsp_err_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      be_q        <= be_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dat_q   <= rsp_dat_d;
      rsp_err_q   <= rsp_err_d;
      cnt_q       <= cnt_d;
    end
  assign cmd_ready_o    = ready_q;
  assign rsp_valid_o    = rsp_valid_q;
  assign rsp_dat_o      = rsp_dat_q;
  assign rsp_err_o      = rsp_err_q;
  assign WBm_ADR_o      = adr_q;
  assign WBm_CYC_o      = cyc_q;
  assign WBm_STB_o      = cyc_q;
  assign WBm_WE_o       = we_q;
  assign WBm_BYTE_STB_o = be_q;
  assign WBm_DAT_o      = dat_q;
  assign busy_o         = (state_q != IDLE);
  assign txn_count_o    = cnt_q;
endmodule

// File: tb/tb_wb_register_master.sv
// tb_wb_register_master: scoreboard bench for wb_register_master against a registered-ACK register slave.
module tb_wb_register_master;
  localparam int AW = 7, DW = 32, CW = 4;
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
  logic [AW-1:0] cmd_adr = '0;
  logic [DW-1:0] cmd_dat = '0;
  logic [3:0]    cmd_be = '0;
  logic          rsp_valid, rsp_ready = 1'b1, rsp_err;
  logic [DW-1:0] rsp_dat;
  logic [AW-1:0] wbm_adr;
  logic          wbm_cyc, wbm_stb, wbm_we;
  logic [3:0]    wbm_be;
  logic [DW-1:0] wbm_dat_o;
  logic [DW-1:0] sdat_q;
  logic          ack_q;
  logic          busy;
  logic [CW-1:0] txn_count;
  always #5 clk = ~clk;

  wb_register_master #(.ADDRWIDTH(AW), .DATAWIDTH(DW), .TIMEOUT_CYCLES(16), .CNTWIDTH(CW)) dut (
    .WBs_CLK_i(clk), .WBs_RST_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
    .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat), .cmd_be_i(cmd_be),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_dat_o(rsp_dat), .rsp_err_o(rsp_err),
    .WBm_ADR_o(wbm_adr), .WBm_CYC_o(wbm_cyc), .WBm_STB_o(wbm_stb), .WBm_WE_o(wbm_we),
    .WBm_BYTE_STB_o(wbm_be), .WBm_DAT_o(wbm_dat_o), .WBm_DAT_i(sdat_q), .WBm_ACK_i(ack_q),
    .busy_o(busy), .txn_count_o(txn_count)
  );

  typedef struct packed {logic e; logic [CW-1:0] c; logic [DW-1:0] d;} exp_t;
  exp_t          sb[$];
  int            checks = 0, errors = 0, acks = 0;
  logic [CW-1:0] exp_cnt = '0;
  logic          mute = 1'b0;
  logic [31:0]   mem [16];

  // Register slave: 16 mapped words, registered single-pulse ACK, unmapped reads return a marker.
  always @(posedge clk or posedge rst)
    if (rst) begin
      ack_q  <= 1'b0;
      sdat_q <= '0;
      for (int i = 0; i < 16; i++) mem[i] <= (i == 0) ? 32'hFEED_2BEE : 32'h0;
    end else begin
      ack_q <= wbm_cyc && wbm_stb && !ack_q && !mute;
      if (wbm_cyc && wbm_stb && !ack_q && !mute) begin
        acks <= acks + 1;
        if (wbm_we) begin
          if (wbm_adr < 16)
            for (int b = 0; b < 4; b++)
              if (wbm_be[b]) mem[wbm_adr[3:0]][8*b +: 8] <= wbm_dat_o[8*b +: 8];
        end else sdat_q <= (wbm_adr < 16) ? mem[wbm_adr[3:0]] : 32'hAA55_6699;
      end
    end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every response handshake is compared against the oldest expectation.
  always @(negedge clk)
    if (rsp_valid && rsp_ready) begin
      if (sb.size() == 0) check("unexpected_rsp", 1, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        check("rsp_dat", rsp_dat, e.d);
        check("rsp_err", rsp_err, e.e);
        check("rsp_count", txn_count, e.c);
      end
    end

  task automatic do_cmd(input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                        input logic [3:0] be, input logic [DW-1:0] xd, input logic xe, input logic push);
    int n = 0;
    while (!cmd_ready && n < 50) begin @(posedge clk); #1; n++; end
    check("cmd_ready", cmd_ready, 1);
    if (push) begin
      exp_cnt = exp_cnt + 1'b1;
      sb.push_back('{e: xe, c: exp_cnt, d: xd});
    end
    cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_be = be;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin @(posedge clk); #1; n++; end
    check("rsp_wait", sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, n;
    repeat (2) @(posedge clk);
    #1;
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_cyc", wbm_cyc, 0);
    check("rst_stb", wbm_stb, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_count", txn_count, 0);
    check("rst_rsp_dat", rsp_dat, 0);
    rst = 1'b0;
    // Single write with bus-phase timing checks.
    a0 = acks;
    do_cmd(1'b1, 7'h3, 32'h1234_5678, 4'hF, 32'h0, 1'b0, 1'b1);
    check("wr_cyc", wbm_cyc, 1);
    check("wr_stb", wbm_stb, 1);
    check("wr_we", wbm_we, 1);
    check("wr_adr", wbm_adr, 7'h3);
    check("wr_dat", wbm_dat_o, 32'h1234_5678);
    check("wr_busy", busy, 1);
    @(posedge clk); #1;
    check("wr_cyc_hold", wbm_cyc, 1);
    @(posedge clk); #1;
    check("wr_cyc_drop", wbm_cyc, 0);
    check("wr_rsp_valid", rsp_valid, 1);
    wait_rsp();
    repeat (3) @(posedge clk);
    #1;
    check("wr_one_ack", acks - a0, 1);
    check("wr_we_kept", wbm_we, 1);
    // Read-back, reset-value word, unmapped address.
    do_cmd(1'b0, 7'h3, 32'h0, 4'hF, 32'h1234_5678, 1'b0, 1'b1);
    wait_rsp();
    do_cmd(1'b0, 7'h0, 32'h0, 4'hF, 32'hFEED_2BEE, 1'b0, 1'b1);
    wait_rsp();
    do_cmd(1'b0, 7'h7F, 32'h0, 4'hF, 32'hAA55_6699, 1'b0, 1'b1);
    wait_rsp();
    // Backpressure with a competing command that must be ignored.
    rsp_ready = 1'b0;
    do_cmd(1'b0, 7'h3, 32'h0, 4'hF, 32'h1234_5678, 1'b0, 1'b1);
    n = 0;
    while (!rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
    check("bp_valid", rsp_valid, 1);
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 7'h5; cmd_dat = 32'hCAFE_0005; cmd_be = 4'h3;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_hold_valid", rsp_valid, 1);
      check("bp_hold_dat", rsp_dat, 32'h1234_5678);
      check("bp_cmd_ready", cmd_ready, 0);
      check("bp_no_cyc", wbm_cyc, 0);
    end
    exp_cnt = exp_cnt + 1'b1;
    sb.push_back('{e: 1'b0, c: exp_cnt, d: 32'h0});
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_ready", cmd_ready, 1);
    check("bp_release_valid", rsp_valid, 0);
    check("bp_release_cyc", wbm_cyc, 0);
    @(posedge clk); #1;
    check("bp_accept_cyc", wbm_cyc, 1);
    check("bp_accept_adr", wbm_adr, 7'h5);
    cmd_valid = 1'b0;
    wait_rsp();
    do_cmd(1'b0, 7'h5, 32'h0, 4'hF, 32'h0000_0005, 1'b0, 1'b1);
    wait_rsp();
    // Silent slave: timeout error response, or an indefinite wait without the feature.
    mute = 1'b1;
`ifdef WBM_TIMEOUT_EN
    do_cmd(1'b0, 7'h1, 32'h0, 4'hF, 32'h0, 1'b1, 1'b1);
    n = 0;
    while (wbm_cyc && n < 100) begin n++; @(posedge clk); #1; end
    check("to_cyc_cycles", n, 16);
    check("to_rsp_err", rsp_err, 1);
    wait_rsp();
    do_cmd(1'b0, 7'h1, 32'h0, 4'hF, 32'h0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
`else
    do_cmd(1'b0, 7'h1, 32'h0, 4'hF, 32'h0, 1'b0, 1'b0);
    repeat (1000) @(posedge clk);
    #1;
    check("hang_rsp_valid", rsp_valid, 0);
`endif
    check("midbus_cyc", wbm_cyc, 1);
    rst = 1'b1;
    #1;
    check("midbus_rst_cyc", wbm_cyc, 0);
    check("midbus_rst_stb", wbm_stb, 0);
    check("midbus_rst_valid", rsp_valid, 0);
    check("midbus_rst_busy", busy, 0);
    check("midbus_rst_count", txn_count, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    mute = 1'b0;
    exp_cnt = '0;
    do_cmd(1'b1, 7'h2, 32'h0BAD_F00D, 4'hF, 32'h0, 1'b0, 1'b1);
    wait_rsp();
    do_cmd(1'b0, 7'h2, 32'h0, 4'hF, 32'h0BAD_F00D, 1'b0, 1'b1);
    wait_rsp();
    // Counter wrap over 17 writes from reset.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_cnt = '0;
    for (int i = 1; i <= 17; i++) begin
      do_cmd(1'b1, AW'(i % 16), DW'(i), 4'hF, 32'h0, 1'b0, 1'b1);
      wait_rsp();
      check("wrap_count", txn_count, i % 16);
    end
    repeat (5) @(posedge clk);
    #1;
    check("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
